pwm_peripheral: RTL and testbench
=================================

// Module: pwm_peripheral
// PURPOSE
//   Consumes the register file written over SPI and drives 16 output pins.
//   Each pin is forced low, forced high, or driven by one shared PWM waveform.
//   All pins share a single 8-bit duty cycle.
//   Sits directly downstream of the SPI register block. Its outputs go to uo_out/uio_out.
// PARAMETERS
//   PRESCALE  13  clk cycles per PWM count step (>=1); 10 MHz/13/256 ~= 3 kHz
// PORTS
//   clk              input   1  system clock; all state on posedge clk
//   rst              input   1  synchronous, active-high reset
//   en_reg_out_7_0   input   8  output enable, pins 7..0 (1 = pin active)
//   en_reg_out_15_8  input   8  output enable, pins 15..8
//   en_reg_pwm_7_0   input   8  PWM select, pins 7..0 (1 = PWM, 0 = static high)
//   en_reg_pwm_15_8  input   8  PWM select, pins 15..8
//   pwm_duty_cycle   input   8  duty: 0x00 = 0%, 0xFF = 100%, else duty/256
//   out              output 16  registered pin drive; out[15:8] maps to the *_15_8 registers
//   period_start     output  1  1-cycle pulse, aligned with out, on the first cycle of each period
// BEHAVIOUR
//   Reset (rst=1 at posedge): pre_cnt=0, pwm_cnt=0, duty_sh=0, out=0, period_start=0.
//     Reset is honoured mid-period; the next period starts cleanly from count 0.
//   Prescaler: pre_cnt counts 0..PRESCALE-1, then wraps to 0.
//     step = (pre_cnt == PRESCALE-1).
//     PRESCALE=1: step is high every cycle.
//   Period counter: 8-bit pwm_cnt increments on step and wraps 255 -> 0 naturally.
//     One period = 256*PRESCALE clk cycles.
//   Period-start cycle: ps = (pre_cnt==0 && pwm_cnt==0).
//     This includes the first cycle after reset is released.
//   Duty shadow: on a ps cycle, duty_sh <= pwm_duty_cycle.
//     duty_eff = ps ? pwm_duty_cycle : duty_sh.
//     Duty writes mid-period take effect only at the next period start (glitch-free).
//   PWM level: pwm = (duty_eff==8'hFF) ? 1 : (pwm_cnt < duty_eff).
//     duty 0x00 gives a constant low.
//     duty N (1..254) gives N*PRESCALE high cycles, then low for the rest of the period.
//   Per pin i, next-state values:
//     out[i]       <= en_out[i] ? (en_pwm[i] ? pwm : 1'b1) : 1'b0
//     period_start <= ps
//   Latency: enable and select inputs appear on out 1 clk cycle later, not shadowed.
//     The PWM waveform is delayed 1 cycle from the counter state.
//   en_out=0 overrides en_pwm: the pin is 0 regardless of duty.
//   Inputs are assumed synchronous to clk; this block applies no CDC.
// TESTING
//   1. rst=1 held 3 cycles with all enables 0xFF and duty 0x80
//      -> out==0 and period_start==0 throughout;
//      first cycle after release -> period_start pulses 1 cycle later.
//   2. PRESCALE=2, en_out=0xFFFF, en_pwm=0x0000
//      -> out==0xFFFF from 1 cycle after the inputs settle, no toggling.
//   3. PRESCALE=2, en_out=en_pwm=0xFFFF, duty=0x40
//      -> each period is 512 cycles, out==0xFFFF for 128 cycles, then 0x0000 for 384.
//   4. duty=0x00 -> out stays 0; duty=0xFF -> out stays 0xFFFF across 3 full periods.
//   5. duty 0x40 -> 0xC0 written mid-period
//      -> the current period keeps 128 high cycles; the next period shows 384.
//   6. en_out=0x00FF, en_pwm=0xFF00, duty=0x80
//      -> out[7:0]==0xFF static; out[15:8]==0 (en_out overrides en_pwm).

Source files
------------

// File: rtl/pwm_if.sv
// Register-file to PWM peripheral connection: enable/select/duty inputs and pin drive outputs.
interface pwm_if;
   logic [7:0]  en_reg_out_7_0;
   logic [7:0]  en_reg_out_15_8;
   logic [7:0]  en_reg_pwm_7_0;
   logic [7:0]  en_reg_pwm_15_8;
   logic [7:0]  pwm_duty_cycle;
   logic [15:0] out;
   logic        period_start;

   modport master (
      output en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle,
      input  out, period_start
   );

   modport slave (
      input  en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle,
      output out, period_start
   );
endinterface

// File: rtl/pwm_peripheral.sv
// Drives 16 pins low, high or from one shared PWM waveform whose duty is latched
// at each period start so mid-period duty writes never glitch the output.
module pwm_peripheral #(
   parameter int PRESCALE = 13
) (
   input  logic clk,
   input  logic rst,
   pwm_if.slave bus
);

   localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PRESCALE - 1);

   logic [PRE_W-1:0] pre_cnt_r;
   logic [7:0]       pwm_cnt_r;
   logic [7:0]       duty_sh_r;
   logic [15:0]      out_r;
   logic             period_start_r;

   logic             step_s;
   logic             ps_s;
   logic [7:0]       duty_eff_s;
   logic             pwm_s;
   logic [15:0]      en_out_s;
   logic [15:0]      en_pwm_s;
   logic [15:0]      out_nxt_s;
   logic [PRE_W-1:0] pre_nxt_s;

   // Counter decode, effective duty and next pin values.
   always_comb begin
      en_out_s = {bus.en_reg_out_15_8, bus.en_reg_out_7_0};
      en_pwm_s = {bus.en_reg_pwm_15_8, bus.en_reg_pwm_7_0};
      step_s   = (pre_cnt_r == PRE_MAX);
      ps_s     = (pre_cnt_r == {PRE_W{1'b0}}) && (pwm_cnt_r == 8'd0);
      if (step_s) begin
         pre_nxt_s = {PRE_W{1'b0}};
      end else begin
         pre_nxt_s = pre_cnt_r + {{(PRE_W-1){1'b0}}, 1'b1};
      end
      if (ps_s) begin
         duty_eff_s = bus.pwm_duty_cycle;
      end else begin
         duty_eff_s = duty_sh_r;
      end
      // 0xFF is special-cased so the waveform reaches a true 100%.
      if (duty_eff_s == 8'hFF) begin
         pwm_s = 1'b1;
      end else begin
         pwm_s = (pwm_cnt_r < duty_eff_s);
      end
      out_nxt_s = en_out_s & (~en_pwm_s | {16{pwm_s}});
   end

   // Prescaler, period counter, duty shadow and registered pin drive.
   always_ff @(posedge clk) begin
      if (rst) begin
         pre_cnt_r      <= {PRE_W{1'b0}};
         pwm_cnt_r      <= 8'd0;
         duty_sh_r      <= 8'd0;
         out_r          <= 16'd0;
         period_start_r <= 1'b0;
      end else begin
         pre_cnt_r      <= pre_nxt_s;
         if (step_s) begin
            pwm_cnt_r <= pwm_cnt_r + 8'd1;
         end
         if (ps_s) begin
            duty_sh_r <= bus.pwm_duty_cycle;
         end
         out_r          <= out_nxt_s;
         period_start_r <= ps_s;
      end
   end

   assign bus.out          = out_r;
   assign bus.period_start = period_start_r;

endmodule

// File: tb/tb_pwm_peripheral.sv
// Randomized and directed bench for pwm_peripheral against a time-based reference model.
module tb_pwm_peripheral;

   localparam int P   = 2;
   localparam int PER = 256 * P;

   logic clk;
   logic rst;
   pwm_if bus ();

   pwm_peripheral #(.PRESCALE(P)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int          check_cnt = 0;
   int          err_cnt   = 0;
   int          t_m       = 0;
   logic [7:0]  duty_m    = 8'd0;
   logic [15:0] exp_out   = 16'd0;
   logic        exp_ps    = 1'b0;
   int          hi_cnt    = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      check_cnt++;
      if (obs !== exp) begin
         err_cnt++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic set_inputs(input logic [15:0] en_o, input logic [15:0] en_p, input logic [7:0] duty);
      bus.en_reg_out_7_0  = en_o[7:0];
      bus.en_reg_out_15_8 = en_o[15:8];
      bus.en_reg_pwm_7_0  = en_p[7:0];
      bus.en_reg_pwm_15_8 = en_p[15:8];
      bus.pwm_duty_cycle  = duty;
   endtask

   // Reference: time since reset release gives position within the period directly.
   task automatic model_step();
      int          phase;
      int          cnt;
      logic        pwm;
      logic [15:0] en_o;
      logic [15:0] en_p;
      en_o = {bus.en_reg_out_15_8, bus.en_reg_out_7_0};
      en_p = {bus.en_reg_pwm_15_8, bus.en_reg_pwm_7_0};
      if (rst) begin
         exp_out = 16'd0;
         exp_ps  = 1'b0;
         t_m     = 0;
      end else begin
         phase = t_m % PER;
         cnt   = phase / P;
         if (phase == 0) duty_m = bus.pwm_duty_cycle;
         pwm     = (duty_m == 8'hFF) || (cnt < int'(duty_m));
         exp_ps  = (phase == 0);
         exp_out = en_o & (pwm ? 16'hFFFF : ~en_p);
         t_m++;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      check_val("out", {16'd0, bus.out}, {16'd0, exp_out});
      check_val("period_start", {31'd0, bus.period_start}, {31'd0, exp_ps});
      if (bus.out == 16'hFFFF) hi_cnt++;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic align_period();
      while ((t_m % PER) != 0) tick();
   endtask

   initial begin
      rst = 1'b1;
      set_inputs(16'hFFFF, 16'hFFFF, 8'h80);
      // Reset held 3 cycles with everything enabled.
      run(3);
      check_val("rst_out", {16'd0, bus.out}, 32'd0);
      rst = 1'b0;
      tick();
      check_val("first_ps", {31'd0, bus.period_start}, 32'd1);

      // Static high with PWM deselected.
      set_inputs(16'hFFFF, 16'h0000, 8'h40);
      run(2);
      hi_cnt = 0;
      run(300);
      check_val("static_hi_cnt", hi_cnt, 32'd300);

      // duty 0x40: 128 high cycles per 512-cycle period.
      set_inputs(16'hFFFF, 16'hFFFF, 8'h40);
      align_period();
      hi_cnt = 0;
      run(PER);
      check_val("duty40_hi", hi_cnt, 32'd128);

      // duty 0x00 and 0xFF over 3 periods each.
      set_inputs(16'hFFFF, 16'hFFFF, 8'h00);
      align_period();
      hi_cnt = 0;
      run(3 * PER);
      check_val("duty00_hi", hi_cnt, 32'd0);
      set_inputs(16'hFFFF, 16'hFFFF, 8'hFF);
      align_period();
      hi_cnt = 0;
      run(3 * PER);
      check_val("dutyFF_hi", hi_cnt, 32'd1536);

      // Mid-period duty write is deferred to the next period.
      set_inputs(16'hFFFF, 16'hFFFF, 8'h40);
      align_period();
      hi_cnt = 0;
      run(100);
      set_inputs(16'hFFFF, 16'hFFFF, 8'hC0);
      run(PER - 100);
      check_val("mid_cur_hi", hi_cnt, 32'd128);
      hi_cnt = 0;
      run(PER);
      check_val("mid_next_hi", hi_cnt, 32'd384);

      // en_out overrides en_pwm.
      set_inputs(16'h00FF, 16'hFF00, 8'h80);
      run(PER);
      check_val("override", {16'd0, bus.out}, 32'h0000_00FF);

      // Reset honoured mid-period.
      run(77);
      rst = 1'b1;
      run(2);
      rst = 1'b0;
      run(300);

      // Random segments with occasional resets.
      for (int s = 0; s < 24; s++) begin
         set_inputs(16'($urandom), 16'($urandom), 8'($urandom));
         if ($urandom_range(0, 7) == 0) begin
            rst = 1'b1;
            run(int'($urandom_range(1, 3)));
            rst = 1'b0;
         end
         run(int'($urandom_range(1, 600)));
      end

      $display("CHECKS %0d ERRORS %0d", check_cnt, err_cnt);
      $finish;
   end

endmodule
